// File: rtl/nn_pkg.sv
// Shared neural-network datapath definitions: default word/layer sizes,
// index-width helper and the fixed-point word type used by MAC/neuron blocks.
package nn_pkg;

    localparam int NN_WORD_W  = 32;
    localparam int NN_LAYER_N = 8;

    typedef logic [NN_WORD_W-1:0] fxp_word_t;

    // Width needed to index n elements; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/vec_slot.sv
// One vector storage slot: an N*n-bit register with a full flag, load/clear
// controls and a combinational element selector.
module vec_slot import nn_pkg::*; #(
    parameter int N  = NN_LAYER_N,
    parameter int n  = NN_WORD_W,
    parameter int IW = idx_width(NN_LAYER_N)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           load,
    input  logic           clear,
    input  logic [N*n-1:0] data_in,
    input  logic [IW-1:0]  sel,
    output logic           full,
    output logic [N*n-1:0] data_out,
    output logic [n-1:0]   elem_out
);

    logic [N*n-1:0] data_q, data_d;
    logic           full_q, full_d;

    // Load wins over clear so a slot can be emptied and refilled in one cycle.
    always_comb begin
        data_d = data_q;
        full_d = full_q;
        if (load) begin
            data_d = data_in;
            full_d = 1'b1;
        end else if (clear) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_q <= '0;
            full_q <= 1'b0;
        end else begin
            data_q <= data_d;
            full_q <= full_d;
        end
    end

    always_comb begin
        elem_out = '0;
        for (int i = 0; i < N; i++) begin
            if (sel == IW'(i)) begin
                elem_out = data_q[n*i +: n];
            end
        end
    end

    assign full     = full_q;
    assign data_out = data_q;

endmodule

// File: rtl/layer_serializer.sv
// Double-buffered parallel-to-serial converter between neuron layers.
// Define LAYER_SERIALIZER_RELU_EN to apply ReLU to H_out combinationally.
module layer_serializer import nn_pkg::*; #(
    parameter int N  = NN_LAYER_N,
    parameter int n  = NN_WORD_W,
    parameter int IW = idx_width(N)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N*n-1:0] Y_in,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [n-1:0]   H_out,
    output logic [IW-1:0]  out_idx,
    output logic           out_last,
    output logic           busy
);

    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

    logic           active_full, pending_full;
    logic [N*n-1:0] pending_data, active_load_data, active_data_unused;
    logic [n-1:0]   active_elem, pending_elem_unused, relu_elem;
    logic [IW-1:0]  idx_q, idx_d;
    logic           accept, out_hs, done;
    logic           load_from_in, pending_load, move_up, active_load, active_clear;

    // A vector goes straight to the active slot when it is empty or finishing
    // this cycle; otherwise it parks in pending until the active one drains.
    always_comb begin
        in_ready         = !pending_full && !reset;
        accept           = in_valid && in_ready;
        out_hs           = active_full && out_ready;
        done             = out_hs && (idx_q == LAST_IDX);
        load_from_in     = accept && (!active_full || done);
        pending_load     = accept && !load_from_in;
        move_up          = done && pending_full && !accept;
        active_load      = load_from_in || move_up;
        active_clear     = done && !pending_full && !accept;
        active_load_data = move_up ? pending_data : Y_in;

        idx_d = idx_q;
        if (active_load) begin
            idx_d = '0;
        end else if (out_hs) begin
            idx_d = done ? '0 : idx_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idx_q <= '0;
        end else begin
            idx_q <= idx_d;
        end
    end

    vec_slot #(.N(N), .n(n), .IW(IW)) u_active (
        .clk      (clk),
        .reset    (reset),
        .load     (active_load),
        .clear    (active_clear),
        .data_in  (active_load_data),
        .sel      (idx_q),
        .full     (active_full),
        .data_out (active_data_unused),
        .elem_out (active_elem)
    );

    vec_slot #(.N(N), .n(n), .IW(IW)) u_pending (
        .clk      (clk),
        .reset    (reset),
        .load     (pending_load),
        .clear    (move_up),
        .data_in  (Y_in),
        .sel      ('0),
        .full     (pending_full),
        .data_out (pending_data),
        .elem_out (pending_elem_unused)
    );

`ifdef LAYER_SERIALIZER_RELU_EN
    assign relu_elem = active_elem[n-1] ? '0 : active_elem;
`else
    assign relu_elem = active_elem;
`endif

    assign out_valid = active_full;
    assign H_out     = active_full ? relu_elem : '0;
    assign out_idx   = idx_q;
    assign out_last  = active_full && (idx_q == LAST_IDX);
    assign busy      = active_full || pending_full;

endmodule

// File: doc/layer_serializer.md
Name: layer_serializer

Overview:
- Parallel-to-serial converter between neuron layers.
- Takes the N-element vector produced by a layer of parallel MACs (N*n bits, one word per neuron) and streams it one n-bit word per cycle as the scalar H input to the next layer.
- Double-buffered, so a following vector is accepted while the current one streams, with no bubble between vectors.
- Valid/ready handshake on both sides.

Parameters:
- N, 8, vector elements per transfer (neurons in producing layer); N >= 1
- n, 32, word width in bits (two's-complement fixed point)
- IW, $clog2(N) (min 1), width of out_idx

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- in_valid  in  1  Y_in holds a valid vector
- in_ready  out  1  block can accept a vector this cycle
- Y_in  in  N*n  vector; element i (0-based) = Y_in[n*(i+1)-1 -: n]
- out_valid  out  1  H_out holds a valid element
- out_ready  in  1  consumer accepts H_out this cycle
- H_out  out  n  current element
- out_idx  out  IW  index of current element within its vector
- out_last  out  1  current element is element N-1
- busy  out  1  active or pending buffer occupied

Behaviour:
- Single clock; reset is synchronous and active-high.
- Storage is two vector slots: `active` (being streamed) and `pending`. Each slot has a full flag.
- in_ready = !pending_full && !reset, which is combinational.
- An accept occurs when in_valid && in_ready. An output handshake occurs when out_valid && out_ready.
- `done` = output handshake && idx == N-1.
- Accept routing:
  - If active is empty, or `done` occurs in the same cycle, the vector loads directly into active and idx is set to 0.
  - Otherwise the vector loads into pending.
- Active refill: when `done` occurs with pending full and no accept, pending moves to active and pending_full clears. This is the normal back-to-back case.
- Active empties when `done` occurs, pending is empty and there is no accept.
- idx increments on every output handshake and wraps N-1 -> 0 at vector end.
- Outputs:
  - out_valid = active_full.
  - H_out = active element idx.
  - out_idx = idx.
  - out_last = out_valid && idx == N-1.
- Latency: a vector accepted at cycle t into an empty block gives out_valid=1 with element 0 at t+1.
- Throughput: one element per cycle while out_ready=1. Vector k+1 element 0 follows vector k element N-1 on the next cycle with no gap.
- Stall: while out_valid && !out_ready, H_out, out_idx and out_last are held stable.
- Stored vectors never change once stored; Y_in is sampled only on accept.
- N == 1: every element has out_last=1 and out_idx=0.
- Both slots full: in_ready=0, and stays 0 until active completes and pending moves up. Accept and pending-move never coincide, because in_ready=0 whenever pending is full.
- busy = active_full || pending_full.
- Reset (synchronous, takes priority over all other activity, including mid-stream):
  - active and pending are cleared.
  - idx is set to 0.
  - Output values: out_valid=0, out_last=0, out_idx=0, H_out=0, busy=0, in_ready=0 during reset, 1 on the cycle after.
  - The partially streamed vector is discarded with no further output.

Optional Feature:
- Macro: LAYER_SERIALIZER_RELU_EN.
- Defined: H_out = 0 when the selected element's MSB is 1, otherwise the element unchanged. This applies ReLU to the data path combinationally with no added latency.
- Undefined: H_out is the raw element.
- Handshake, indexing and timing are identical in both builds.

Decomposition:
- Shared package nn_pkg holds:
  - word width default (32) and layer size default (8);
  - the index-width helper (clog2 with minimum 1);
  - a fixed-point word typedef reused by the MAC/neuron blocks.
- One sub-module is natural: vec_slot, an N*n register with full flag, load and clear inputs, and element-select output. It is instantiated twice (active, pending).
- Handshake, routing and the idx counter stay in the top module.

Test Plan:
1. Basic stream (N=8, n=32):
   - Stimulus: reset, then accept Y_in with element i = i+1, out_ready=1.
   - Required: H_out = 1..8 on consecutive cycles starting t+1; out_last only on value 8; out_valid=0 after.
2. Back-to-back:
   - Stimulus: present vector A (0x10..0x17) then vector B (0x20..0x27) with in_valid held.
   - Required: 16 consecutive out_valid cycles; 0x17 is immediately followed by 0x20; in_ready drops to 0 while both slots are full.
3. Back-pressure:
   - Stimulus: out_ready=0 for 3 cycles at idx=2.
   - Required: H_out=3 and out_idx=2 held for all 3 cycles; streaming resumes with 4; no element is lost or duplicated.
4. Reset mid-operation:
   - Stimulus: assert reset at idx=5 with pending full.
   - Required: next cycle out_valid=0, busy=0, out_idx=0; after release, a new vector streams from element 0 and no old data appears.
5. N=1 build:
   - Stimulus: stream values 7, 9, 11.
   - Required: each element has out_last=1 and out_idx=0; one element per cycle when in_valid/out_ready are continuous.
6. LAYER_SERIALIZER_RELU_EN defined:
   - Stimulus: elements 0xFFFFFFFF, 0x00000005, 0x80000000, 0x7FFFFFFF.
   - Required: H_out = 0, 5, 0, 0x7FFFFFFF.
   - Same stimulus with the macro undefined yields the raw values.
